// File: rtl/cpu_pkg.sv
// Shared CPU pipeline package.
// Contents:
//   RESET_PC_DEF, NOP_INSTR_DEF : default reset PC and bubble instruction word
//   fetch_state_t               : fetch FSM states {FETCH, WAIT, DROP}
//   if_id_t                     : IF/ID pipeline register contents {instr, pc4, valid}
//   align_word()                : clears the two low address bits of a target
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // Instruction addresses are word aligned; the low bits of a branch target are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: pipeline register between two stages with load/hold/bubble control.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_instr/in_pc4 and mark the entry valid
//   bubble              : replace the entry with NOP_INSTR and clear valid (wins over load)
//   in_instr, in_pc4    : data captured on load
//   out_instr, out_pc4, out_valid : registered contents
// With neither load nor bubble the register holds.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic        out_valid
);

  if_id_t q_r;

  // Pipeline register update: bubble > load > hold. pc4 is kept on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r.instr <= NOP_INSTR;
      q_r.pc4   <= 32'h0000_0000;
      q_r.valid <= 1'b0;
    end else if (bubble) begin
      q_r.instr <= NOP_INSTR;
      q_r.valid <= 1'b0;
    end else if (load) begin
      q_r.instr <= in_instr;
      q_r.pc4   <= in_pc4;
      q_r.valid <= 1'b1;
    end else begin
      q_r <= q_r;
    end
  end

  assign out_instr = q_r.instr;
  assign out_pc4   = q_r.pc4;
  assign out_valid = q_r.valid;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC, imem handshake and IF/ID register.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_addr/imem_req          : fetch address (= PC) and request (1 once out of reset)
//   imem_rdata/imem_ready       : returned word and its single-cycle completion pulse
//   stall                       : hold PC and IF/ID
//   branch_taken/branch_target  : redirect the PC and flush IF/ID (wins over stall)
//   id_instr/id_pc4/id_valid    : IF/ID register contents delivered to decode
//   perf_fetched/perf_stall     : performance counters, only with FETCH_PERF_CNT_EN defined
// imem_req rises on the first clock after reset release; imem_ready seen while
// imem_req is still low is ignored, so the first word is captured one edge later.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        id_valid
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  pend_tgt_r;
  logic         req_r;
  logic [31:0]  pc4_s;
  logic         load_s;
  logic         bubble_s;

  assign pc4_s     = pc_r + 32'd4;
  assign imem_addr = pc_r;
  assign imem_req  = req_r;

  // IF/ID control: flush on branch, hold on stall, capture on ready, else bubble.
  // A word returning in DROP belongs to a squashed path and is never loaded.
  always_comb begin
    load_s   = 1'b0;
    bubble_s = 1'b0;
    if (req_r) begin
      case (state_r)
        FETCH, WAIT: begin
          if (branch_taken) begin
            bubble_s = 1'b1;
          end else if (stall) begin
            bubble_s = 1'b0;
          end else if (imem_ready) begin
            load_s = 1'b1;
          end else begin
            bubble_s = 1'b1;
          end
        end
        DROP: begin
          if (branch_taken) begin
            bubble_s = 1'b1;
          end else if (stall) begin
            bubble_s = 1'b0;
          end else begin
            bubble_s = 1'b1;
          end
        end
        default: bubble_s = 1'b1;
      endcase
    end else begin
      load_s   = 1'b0;
      bubble_s = 1'b0;
    end
  end

  // Fetch FSM: PC only moves on imem_ready so the address is stable while outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      pend_tgt_r <= 32'h0000_0000;
      req_r      <= 1'b0;
    end else begin
      req_r <= 1'b1;
      if (req_r) begin
        case (state_r)
          FETCH, WAIT: begin
            if (branch_taken) begin
              if (imem_ready) begin
                pc_r    <= align_word(branch_target);
                state_r <= FETCH;
              end else begin
                pend_tgt_r <= align_word(branch_target);
                state_r    <= DROP;
              end
            end else if (imem_ready) begin
              state_r <= FETCH;
              if (!stall) begin
                pc_r <= pc4_s;
              end
            end else begin
              state_r <= WAIT;
            end
          end
          DROP: begin
            if (imem_ready) begin
              pc_r    <= branch_taken ? align_word(branch_target) : pend_tgt_r;
              state_r <= FETCH;
            end else if (branch_taken) begin
              pend_tgt_r <= align_word(branch_target);
            end
          end
          default: state_r <= FETCH;
        endcase
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .bubble    (bubble_s),
    .in_instr  (imem_rdata),
    .in_pc4    (pc4_s),
    .out_instr (id_instr),
    .out_pc4   (id_pc4),
    .out_valid (id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Counters: words delivered to decode, and cycles stalled or not in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_r <= 32'h0000_0000;
      perf_stall_r   <= 32'h0000_0000;
    end else begin
      if (load_s) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end
      if (stall || (state_r != FETCH)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The instruction memory returns
// E3A01005 at address 0 and (addr ^ A5A5A5A5) elsewhere; expected words are
// written out as constants.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall),
`endif
    .id_valid      (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr == 32'h0000_0000) ? 32'hE3A0_1005
                                                   : (imem_addr ^ 32'hA5A5_A5A5);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0000_0000;
    step(); step();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, 32'h0000_0000);
    check("rst_pc4",   id_pc4, 32'h0000_0000);
    check("rst_addr",  imem_addr, 32'h0000_0000);

    rst_n = 1'b1;
    step();  // ready ignored in first cycle after release
    check("rel_req",   {31'd0, imem_req}, 32'd1);
    check("rel_valid", {31'd0, id_valid}, 32'd0);
    check("rel_addr",  imem_addr, 32'h0000_0000);
    step();
    check("f0_instr", id_instr, 32'hE3A0_1005);
    check("f0_pc4",   id_pc4, 32'h0000_0004);
    check("f0_valid", {31'd0, id_valid}, 32'd1);
    check("f0_addr",  imem_addr, 32'h0000_0004);
    step();
    check("f4_instr", id_instr, 32'hA5A5_A5A1);
    check("f4_addr",  imem_addr, 32'h0000_0008);

    // Stall two cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stl_instr", id_instr, 32'hA5A5_A5A1);
      check("stl_pc4",   id_pc4, 32'h0000_0008);
      check("stl_valid", {31'd0, id_valid}, 32'd1);
      check("stl_addr",  imem_addr, 32'h0000_0008);
    end
    stall = 1'b0;
    step();
    check("f8_instr", id_instr, 32'hA5A5_A5AD);
    check("f8_pc4",   id_pc4, 32'h0000_000C);
    check("f8_addr",  imem_addr, 32'h0000_000C);
    step();
    check("fc_instr", id_instr, 32'hA5A5_A5A9);
    check("fc_addr",  imem_addr, 32'h0000_0010);

    // Branch while stalled: flush wins
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
    step();
    check("bs_valid", {31'd0, id_valid}, 32'd0);
    check("bs_instr", id_instr, 32'h0000_0000);
    check("bs_addr",  imem_addr, 32'h0000_0100);
    stall = 1'b0; branch_taken = 1'b0;
    step();
    check("f100_instr", id_instr, 32'hA5A5_A4A5);
    check("f100_valid", {31'd0, id_valid}, 32'd1);
    check("f100_addr",  imem_addr, 32'h0000_0104);

    // Wait states, then branch (unaligned target) during WAIT -> DROP
    imem_ready = 1'b0;
    step();
    check("w1_valid", {31'd0, id_valid}, 32'd0);
    check("w1_addr",  imem_addr, 32'h0000_0104);
    branch_taken = 1'b1; branch_target = 32'h0000_0043;
    step();
    branch_taken = 1'b0;
    check("w2_valid", {31'd0, id_valid}, 32'd0);
    check("w2_addr",  imem_addr, 32'h0000_0104);
    step();
    check("w3_addr",  imem_addr, 32'h0000_0104);
    imem_ready = 1'b1;
    step();
    check("drop_valid", {31'd0, id_valid}, 32'd0);
    check("drop_addr",  imem_addr, 32'h0000_0040);
    step();
    check("f40_instr", id_instr, 32'hA5A5_A5E5);
    check("f40_pc4",   id_pc4, 32'h0000_0044);
    check("f40_valid", {31'd0, id_valid}, 32'd1);

    // Wrap at top of address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_instr", id_instr, 32'h5A5A_5A59);
    check("wr_pc4",   id_pc4, 32'h0000_0000);
    check("wr_next",  imem_addr, 32'h0000_0000);

    // Reset in the middle of an outstanding request
    imem_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mr_addr",  imem_addr, 32'h0000_0000);
    check("mr_valid", {31'd0, id_valid}, 32'd0);
    check("mr_req",   {31'd0, imem_req}, 32'd0);
    step();
    imem_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("mr_ign_valid", {31'd0, id_valid}, 32'd0);
    check("mr_ign_addr",  imem_addr, 32'h0000_0000);

    // 10 fetches with 3 stall cycles in between
    for (int i = 0; i < 13; i++) begin
      stall = (i == 3 || i == 4 || i == 8) ? 1'b1 : 1'b0;
      step();
    end
    stall = 1'b0;
    check("cnt_addr", imem_addr, 32'h0000_0028);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd10);
    check("perf_stall",   perf_stall, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
